// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never marked busy.
module regfile_mp #(
   parameter  int XLEN   = 32,
   parameter  int NREGS  = 32,
   parameter  int NRD    = 2,
   parameter  int NWR    = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic [NREGS-1:0]    busy_vec
);

   logic [XLEN-1:0]  regs   [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] wr_hit;
   logic [XLEN-1:0]  wr_val [NREGS];

   // Later ports overwrite earlier ones, so the highest-indexed port wins a conflict.
   always_comb begin
      wr_hit = '0;
      for (int a = 0; a < NREGS; a++) begin
         wr_val[a] = '0;
      end
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
            wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
            wr_val[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int a = 0; a < NREGS; a++) begin
            regs[a] <= '0;
         end
         busy <= '0;
      end else begin
         regs[0] <= '0;
         busy[0] <= 1'b0;
         for (int a = 1; a < NREGS; a++) begin
            if (wr_hit[a]) begin
               regs[a] <= wr_val[a];
            end
            // A new issue outranks the completing write to the same register.
            if (iss_en && (iss_addr == AW'(a))) begin
               busy[a] <= 1'b1;
            end else if (wr_hit[a]) begin
               busy[a] <= 1'b0;
            end
         end
      end
   end

   assign busy_vec = busy;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          fwd;

      assign ra  = rd_addr[k*AW +: AW];
      assign fwd = (BYPASS != 0) && !i_rst && wr_hit[ra];

      assign rd_data[k*XLEN +: XLEN] = (ra == '0) ? '0 :
                                       fwd        ? wr_val[ra] :
                                                    regs[ra];
      assign rd_busy[k] = fwd ? 1'b0 : busy[ra];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with forwarding, one without,
// both driven from the same stimulus.
module tb_regfile_mp;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;

   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic [31:0] busy_vec_b, busy_vec_n;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   regfile_mp #(.BYPASS(1)) dut_b (
      .i_clk(i_clk), .i_rst(i_rst),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_b)
   );

   regfile_mp #(.BYPASS(0)) dut_n (
      .i_clk(i_clk), .i_rst(i_rst),
      .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = 2'b00;
      iss_en = 1'b0;
   endtask

   initial begin
      i_rst    = 1'b1;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
      tick();
      tick();
      i_rst = 1'b0;

      // Reset state: every address reads zero on both ports.
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         #1;
         chk("rst_rd0_b", rd_data_b[31:0],  32'h0);
         chk("rst_rd1_b", rd_data_b[63:32], 32'h0);
         chk("rst_rd0_n", rd_data_n[31:0],  32'h0);
         chk("rst_rd1_n", rd_data_n[63:32], 32'h0);
      end
      chk("rst_busy_b", busy_vec_b, 32'h0);
      chk("rst_busy_n", busy_vec_n, 32'h0);

      // Write-write conflict on address 5: port 1 wins, also on the bypass path.
      rd_addr = {5'd0, 5'd5};
      wr_en   = 2'b11;
      wr_addr = {5'd5, 5'd5};
      wr_data = {32'h12345678, 32'hDEADBEEF};
      #1;
      chk("ww_byp_b", rd_data_b[31:0], 32'h12345678);
      chk("ww_byp_n", rd_data_n[31:0], 32'h0);
      tick();
      idle();
      #1;
      chk("ww_rd_b", rd_data_b[31:0], 32'h12345678);
      chk("ww_rd_n", rd_data_n[31:0], 32'h12345678);

      // Same-cycle forwarding of a write to address 7 on port 0.
      rd_addr = {5'd5, 5'd7};
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd7};
      wr_data = {32'h0, 32'hA5A5A5A5};
      #1;
      chk("byp7_b", rd_data_b[31:0], 32'hA5A5A5A5);
      chk("byp7_n", rd_data_n[31:0], 32'h0);
      chk("byp7_p1_b", rd_data_b[63:32], 32'h12345678);
      tick();
      idle();
      #1;
      chk("wr7_b", rd_data_b[31:0], 32'hA5A5A5A5);
      chk("wr7_n", rd_data_n[31:0], 32'hA5A5A5A5);

      // Register 0: write and issue are both ignored.
      rd_addr  = {5'd0, 5'd0};
      wr_en    = 2'b01;
      wr_addr  = {5'd0, 5'd0};
      wr_data  = {32'h0, 32'hFFFFFFFF};
      iss_en   = 1'b1;
      iss_addr = 5'd0;
      #1;
      chk("r0_byp_b", rd_data_b[31:0], 32'h0);
      tick();
      idle();
      #1;
      chk("r0_rd_b",   rd_data_b[31:0], 32'h0);
      chk("r0_rd_n",   rd_data_n[31:0], 32'h0);
      chk("r0_busy_b", busy_vec_b, 32'h0);
      chk("r0_busy_n", busy_vec_n, 32'h0);

      // Scoreboard on address 3.
      rd_addr  = {5'd0, 5'd3};
      iss_en   = 1'b1;
      iss_addr = 5'd3;
      tick();
      idle();
      #1;
      chk("iss3_vec_b", busy_vec_b, 32'h8);
      chk("iss3_rdb_b", 32'(rd_busy_b[0]), 32'h1);
      chk("iss3_rdb_n", 32'(rd_busy_n[0]), 32'h1);

      wr_en    = 2'b10;
      wr_addr  = {5'd3, 5'd0};
      wr_data  = {32'h00000033, 32'h0};
      iss_en   = 1'b1;
      iss_addr = 5'd3;
      #1;
      chk("wi3_rdb_b", 32'(rd_busy_b[0]), 32'h0);
      chk("wi3_rdb_n", 32'(rd_busy_n[0]), 32'h1);
      tick();
      idle();
      #1;
      chk("wi3_vec_b", busy_vec_b, 32'h8);
      chk("wi3_vec_n", busy_vec_n, 32'h8);
      chk("wi3_rd_b",  rd_data_b[31:0], 32'h33);

      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {32'h0, 32'h00000044};
      tick();
      idle();
      #1;
      chk("w3_vec_b", busy_vec_b, 32'h0);
      chk("w3_vec_n", busy_vec_n, 32'h0);
      chk("w3_rd_n",  rd_data_n[31:0], 32'h44);

      // Unrelated issue and two writes in one cycle.
      rd_addr  = {5'd11, 5'd10};
      wr_en    = 2'b11;
      wr_addr  = {5'd11, 5'd10};
      wr_data  = {32'h0000BBBB, 32'h0000AAAA};
      iss_en   = 1'b1;
      iss_addr = 5'd9;
      tick();
      idle();
      #1;
      chk("mix_vec_b", busy_vec_b, 32'h00000200);
      chk("mix_rd0_n", rd_data_n[31:0],  32'h0000AAAA);
      chk("mix_rd1_n", rd_data_n[63:32], 32'h0000BBBB);

      // Fill 1..31 with their index, then reset mid-stream with a write pending.
      for (int a = 1; a < 32; a++) begin
         wr_en   = 2'b01;
         wr_addr = {5'd0, 5'(a)};
         wr_data = {32'h0, 32'(a)};
         tick();
      end
      idle();
      iss_en   = 1'b1;
      iss_addr = 5'd22;
      tick();
      idle();
      #1;
      chk("fill_busy_b", busy_vec_b, 32'h00400000);
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         #1;
         chk("fill_rd0_b", rd_data_b[31:0],  32'(a));
         chk("fill_rd1_n", rd_data_n[63:32], 32'(31 - a));
      end

      rd_addr  = {5'd21, 5'd20};
      i_rst    = 1'b1;
      wr_en    = 2'b01;
      wr_addr  = {5'd0, 5'd20};
      wr_data  = {32'h0, 32'h00000BAD};
      iss_en   = 1'b1;
      iss_addr = 5'd21;
      #1;
      chk("rst_nobyp_b", rd_data_b[31:0], 32'd20);
      tick();
      i_rst = 1'b0;
      idle();
      #1;
      chk("mrst_busy_b", busy_vec_b, 32'h0);
      chk("mrst_busy_n", busy_vec_n, 32'h0);
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         #1;
         chk("mrst_rd0_b", rd_data_b[31:0],  32'h0);
         chk("mrst_rd1_n", rd_data_n[63:32], 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port i_clk  input  1  clock, all state updates on rising edge.
REQ-008 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-009 SHALL have port rd_addr  input  NRD*AW  read addresses, port k at bits [k*AW +: AW].
REQ-010 SHALL have port rd_data  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-011 SHALL have port rd_busy  output  NRD  scoreboard busy flag of each read address.
REQ-012 SHALL have port wr_en  input  NWR  write enable per write port.
REQ-013 SHALL have port wr_addr  input  NWR*AW  write addresses.
REQ-014 SHALL have port wr_data  input  NWR*XLEN  write data.
REQ-015 SHALL have port iss_en  input  1  issue strobe: mark iss_addr busy.
REQ-016 SHALL have port iss_addr  input  AW  destination register being issued.
REQ-017 SHALL have port busy_vec  output  NREGS  current busy flag of every register.

Function
REQ-018 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never be busy.
REQ-019 Write: on a rising edge with wr_en[j]=1 and wr_addr[j]!=0, regs[wr_addr[j]] SHALL take wr_data[j]; one-cycle write latency.
REQ-020 Write-write conflict: several enabled ports with the same address SHALL resolve to the highest-indexed port's data.
REQ-021 Read: rd_data[k] SHALL be combinational from rd_addr[k] and register state (zero-cycle latency).
REQ-022 BYPASS=1: if any enabled write targets rd_addr[k]!=0 in the current cycle, rd_data[k] SHALL equal that write's data (highest port wins); BYPASS=0: pre-write value.
REQ-023 Scoreboard: iss_en=1 with iss_addr!=0 SHALL set busy[iss_addr] at the next edge.
REQ-024 An enabled write to address a!=0 SHALL clear busy[a] at the next edge.
REQ-025 Issue and write to the same address in one cycle: busy SHALL end set (the new issue wins); data SHALL still be written.
REQ-026 rd_busy[k] SHALL equal busy[rd_addr[k]], except it SHALL be 0 when BYPASS=1 and a same-cycle write to that address clears it.
REQ-027 Writes and issues to unrelated addresses in one cycle SHALL all take effect independently.
REQ-028 Out-of-range addresses cannot occur (AW exact); no additional checking is required.

Reset
REQ-029 With i_rst=1 at a rising edge, all registers SHALL become 0 and all busy flags 0; writes and issues in that cycle SHALL be discarded.
REQ-030 During reset, rd_data SHALL reflect register state (0 after the first reset edge); bypass SHALL be suppressed while i_rst=1.
REQ-031 Reset asserted mid-stream SHALL take effect on the next edge without requiring a clock-free period.

Verification
REQ-032 Reset, then read all addresses on both ports -> all rd_data=0, busy_vec=0.
REQ-033 wr0 addr5=0xDEADBEEF and wr1 addr5=0x12345678 same cycle; read 5 next cycle -> 0x12345678.
REQ-034 BYPASS=1: write addr7=0xA5A5A5A5 while rd_addr[0]=7 -> rd_data[0]=0xA5A5A5A5 same cycle; BYPASS=0 -> old value 0.
REQ-035 Write addr0=0xFFFFFFFF, issue addr0 -> rd_data=0, busy_vec[0]=0.
REQ-036 Issue addr3 -> busy_vec[3]=1 next cycle; write addr3 plus issue addr3 same cycle -> busy_vec[3]=1, data updated; write alone -> busy_vec[3]=0.
REQ-037 Fill regs 1..31 with index value, assert i_rst one cycle mid-stream with wr_en active -> all regs 0, busy 0, the discarded write absent.
